pe_addr_sequencer: RTL and testbench

//  Parametrised nested-loop sequencer for PE scratchpad access (input/weight/psum pads).

---
 rtl/pe_addr_sequencer_pkg.sv | 18 +
 rtl/pe_addr_sequencer_lp_level.sv | 38 +++
 rtl/pe_addr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pe_addr_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_addr_sequencer_pkg.sv
// Shared definitions for the PE scratchpad address sequencer.
// Holds the sequencer state encoding and the default geometry of one pad sequencer.
package PECfg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WORK,
    STALL,
    DONE
  } AddrSeqState;

  localparam int DEF_NDEPTH = 4;
  localparam int DEF_IDXW   = 8;
  localparam int DEF_STRW   = 8;
  localparam int DEF_ADDRW  = 10;

endpackage

// File: rtl/pe_addr_sequencer_lp_level.sv
// One loop level of the address sequencer: index counter plus offset accumulator.
// Wraps to zero at the end of its trip count and signals a carry to the next level.
module pe_lp_level #(
  parameter int IDXW  = 8,
  parameter int ADDRW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [IDXW-1:0]  size,
  input  logic [ADDRW-1:0] stride,
  output logic [IDXW-1:0]  idx,
  output logic [ADDRW-1:0] off,
  output logic             is_end,
  output logic             carry
);

  // size is already forced to at least 1 by the parent
  assign is_end = (idx == size - 1'b1);
  assign carry  = inc && is_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
      off <= '0;
    end else if (inc) begin
      if (is_end) begin
        idx <= '0;
        off <= '0;
      end else begin
        idx <= idx + 1'b1;
        off <= off + stride;
      end
    end
  end

endmodule

// File: rtl/pe_addr_sequencer.sv
// Nested-loop pad address sequencer: FSM, configuration latch, address adder and
// rdy/ack handshake around a chain of pe_lp_level counters.
module pe_addr_sequencer
  import PECfg::*;
#(
  parameter int NDEPTH = DEF_NDEPTH,
  parameter int IDXW   = DEF_IDXW,
  parameter int STRW   = DEF_STRW,
  parameter int ADDRW  = DEF_ADDRW
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic                   i_abort,
  input  logic [NDEPTH*IDXW-1:0] i_loopSize,
  input  logic [NDEPTH*STRW-1:0] i_stride,
  input  logic [ADDRW-1:0]       i_baseAddr,
  output logic                   Addr_rdy,
  input  logic                   Addr_ack,
  output logic [ADDRW-1:0]       o_addr,
  output logic [NDEPTH*IDXW-1:0] o_loopIdx,
  output logic [NDEPTH-1:0]      o_loopEnd,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef struct packed {
    logic [NDEPTH-1:0][IDXW-1:0] size;
    logic [NDEPTH-1:0][STRW-1:0] stride;
    logic [ADDRW-1:0]            base;
  } AddrSeqCfg;

  AddrSeqState state;
  AddrSeqCfg   cfg;

  logic addr_rdy_q;
  logic busy_q;
  logic done_q;
  logic xfer;
  logic lvl_clr;

  logic [NDEPTH-1:0]                 inc;
  logic [NDEPTH-1:0]                 carry;
  logic [NDEPTH-1:0]                 lvl_end;
  logic [NDEPTH-1:0][IDXW-1:0]       idx;
  logic [NDEPTH-1:0][IDXW-1:0]       eff_size;
  logic [NDEPTH-1:0][ADDRW-1:0]      off;
  logic [NDEPTH-1:0][ADDRW-1:0]      stride_ext;
  logic [ADDRW-1:0]                  addr_sum;

  assign xfer    = addr_rdy_q && Addr_ack;
  assign lvl_clr = (state == IDLE);

  genvar k;
  generate
    for (k = 0; k < NDEPTH; k++) begin : g_level
      assign eff_size[k] = (cfg.size[k] == '0) ? IDXW'(1) : cfg.size[k];

      if (STRW >= ADDRW) begin : g_str_trunc
        assign stride_ext[k] = cfg.stride[k][ADDRW-1:0];
      end else begin : g_str_zext
        assign stride_ext[k] = {{(ADDRW-STRW){1'b0}}, cfg.stride[k]};
      end

      if (k == 0) begin : g_inc_first
        assign inc[k] = xfer;
      end else begin : g_inc_chain
        assign inc[k] = carry[k-1];
      end

      pe_lp_level #(
        .IDXW  (IDXW),
        .ADDRW (ADDRW)
      ) u_level (
        .clk    (i_clk),
        .rst    (i_rst),
        .inc    (inc[k]),
        .clr    (lvl_clr),
        .size   (eff_size[k]),
        .stride (stride_ext[k]),
        .idx    (idx[k]),
        .off    (off[k]),
        .is_end (lvl_end[k]),
        .carry  (carry[k])
      );
    end
  endgenerate

  always_comb begin
    addr_sum = cfg.base;
    for (int i = 0; i < NDEPTH; i++) begin
      addr_sum = addr_sum + off[i];
    end
  end

  // A carry out of the outermost level is exactly a transfer of the final address
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cfg        <= '0;
      addr_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_abort) begin
        state      <= IDLE;
        addr_rdy_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              cfg.size   <= i_loopSize;
              cfg.stride <= i_stride;
              cfg.base   <= i_baseAddr;
              state      <= INIT;
              busy_q     <= 1'b1;
            end
          end
          INIT: begin
            state      <= WORK;
            addr_rdy_q <= 1'b1;
          end
          WORK: begin
            if (carry[NDEPTH-1]) begin
              state      <= DONE;
              addr_rdy_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (i_stall) begin
              state      <= STALL;
              addr_rdy_q <= 1'b0;
            end
          end
          STALL: begin
            if (!i_stall) begin
              state      <= WORK;
              addr_rdy_q <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            addr_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Addr_rdy  = addr_rdy_q;
  assign o_addr    = addr_sum;
  assign o_loopIdx = idx;
  assign o_loopEnd = lvl_end;
  assign o_last    = &lvl_end;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_pe_addr_sequencer.sv
// Self-checking bench for pe_addr_sequencer: a 10-bit and a 4-bit address instance
// share stimulus; expected addresses come from a nested-loop reference model.
module tb_pe_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall, abort, ack;
  logic [31:0] loopSize, stride;
  logic [9:0]  baseAddr;

  logic        rdy, last, busy, done;
  logic [9:0]  addr;
  logic [31:0] idx;
  logic [3:0]  loopEnd;

  logic        rdy4, last4, busy4, done4;
  logic [3:0]  addr4;
  logic [31:0] idx4;
  logic [3:0]  loopEnd4;

  logic        selDut4;
  logic        sRdy, sLast, sBusy, sDone;
  logic [9:0]  sAddr;
  logic [31:0] sIdx;
  logic [3:0]  sEnd;

  int errors = 0;
  int checks = 0;

  int sz[4];
  int st[4];
  int bs;
  int          addrQ[$];
  logic [31:0] idxQ[$];
  logic [3:0]  endQ[$];

  always #5 clk = ~clk;

  pe_addr_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_abort(abort),
    .i_loopSize(loopSize), .i_stride(stride), .i_baseAddr(baseAddr),
    .Addr_rdy(rdy), .Addr_ack(ack), .o_addr(addr), .o_loopIdx(idx),
    .o_loopEnd(loopEnd), .o_last(last), .o_busy(busy), .o_done(done)
  );

  pe_addr_sequencer #(.NDEPTH(4), .IDXW(8), .STRW(4), .ADDRW(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_abort(abort),
    .i_loopSize(loopSize),
    .i_stride({stride[27:24], stride[19:16], stride[11:8], stride[3:0]}),
    .i_baseAddr(baseAddr[3:0]),
    .Addr_rdy(rdy4), .Addr_ack(ack), .o_addr(addr4), .o_loopIdx(idx4),
    .o_loopEnd(loopEnd4), .o_last(last4), .o_busy(busy4), .o_done(done4)
  );

  assign sRdy  = selDut4 ? rdy4 : rdy;
  assign sLast = selDut4 ? last4 : last;
  assign sBusy = selDut4 ? busy4 : busy;
  assign sDone = selDut4 ? done4 : done;
  assign sAddr = selDut4 ? {6'b0, addr4} : addr;
  assign sIdx  = selDut4 ? idx4 : idx;
  assign sEnd  = selDut4 ? loopEnd4 : loopEnd;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  // Reference: plain nested loops, address = base + sum(idx*stride) mod 2^aw
  task automatic buildModel(input int aw);
    int a;
    addrQ.delete();
    idxQ.delete();
    endQ.delete();
    for (int i3 = 0; i3 < eff(sz[3]); i3++)
      for (int i2 = 0; i2 < eff(sz[2]); i2++)
        for (int i1 = 0; i1 < eff(sz[1]); i1++)
          for (int i0 = 0; i0 < eff(sz[0]); i0++) begin
            a = (bs + i0 * st[0] + i1 * st[1] + i2 * st[2] + i3 * st[3]) % (1 << aw);
            addrQ.push_back(a);
            idxQ.push_back({8'(i3), 8'(i2), 8'(i1), 8'(i0)});
            endQ.push_back({i3 == eff(sz[3]) - 1, i2 == eff(sz[2]) - 1,
                            i1 == eff(sz[1]) - 1, i0 == eff(sz[0]) - 1});
          end
  endtask

  task automatic applyStimulus();
    loopSize = {8'(sz[3]), 8'(sz[2]), 8'(sz[1]), 8'(sz[0])};
    stride   = {8'(st[3]), 8'(st[2]), 8'(st[1]), 8'(st[0])};
    baseAddr = 10'(bs);
  endtask

  task automatic startRun();
    applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one full sequence with random ack/stall and checks every cycle
  task automatic runSequence(input bit useDut4, input int ackPct, input int stallPct,
                             input int holdAt, input int stallAt);
    int  n = 0;
    int  cyc = 0;
    int  holdLeft = 0;
    int  stallLeft = 0;
    bit  expRdy = 1'b1;
    bit  finished = 1'b0;
    bit  holdUsed = 1'b0;
    bit  stallUsed = 1'b0;
    selDut4 = useDut4;
    buildModel(useDut4 ? 4 : 10);
    ack = 1'b0;
    stall = 1'b0;
    startRun();
    checkOutput("initRdy", 32'(sRdy), 0);
    checkOutput("initBusy", 32'(sBusy), 1);
    @(negedge clk);
    while (!finished && cyc < 4000) begin
      checkOutput("rdy", 32'(sRdy), 32'(expRdy));
      checkOutput("busy", 32'(sBusy), 1);
      checkOutput("doneEarly", 32'(sDone), 0);
      if (expRdy) begin
        checkOutput("addr", 32'(sAddr), 32'(addrQ[n]));
        checkOutput("idx", sIdx, idxQ[n]);
        checkOutput("loopEnd", 32'(sEnd), 32'(endQ[n]));
        checkOutput("last", 32'(sLast), 32'(n == addrQ.size() - 1));
      end
      ack = ($urandom_range(99) < ackPct);
      if (expRdy && holdAt == n && !holdUsed) begin
        holdLeft = 3;
        holdUsed = 1'b1;
      end
      if (holdLeft > 0) begin
        ack = 1'b0;
        holdLeft--;
      end
      if (expRdy && stallLeft == 0) begin
        if (stallAt == n && !stallUsed) begin
          stallUsed = 1'b1;
          stallLeft = 3;
          ack = 1'b0;
        end else if ($urandom_range(99) < stallPct) begin
          stallLeft = $urandom_range(1, 3);
        end
      end
      stall = (stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
      if (expRdy) begin
        if (ack) begin
          if (n == addrQ.size() - 1) finished = 1'b1;
          else n++;
        end
        if (!finished && stall) expRdy = 1'b0;
      end else if (!stall) begin
        expRdy = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("finished", 32'(finished), 1);
    ack = 1'b0;
    stall = 1'b0;
    checkOutput("donePulse", 32'(sDone), 1);
    checkOutput("doneRdy", 32'(sRdy), 0);
    @(negedge clk);
    checkOutput("doneClear", 32'(sDone), 0);
    checkOutput("idleBusy", 32'(sBusy), 0);
    selDut4 = 1'b0;
  endtask

  task automatic setBasicCfg();
    sz = '{3, 2, 0, 1};
    st = '{1, 4, 0, 0};
    bs = 'h10;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0; ack = 1'b0;
    loopSize = '0; stride = '0; baseAddr = '0; selDut4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rstRdy", 32'(rdy), 0);
    checkOutput("rstAddr", 32'(addr), 0);
    checkOutput("rstIdx", idx, 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(done), 0);

    $display("[TB] basic sequence 10,11,12,14,15,16");
    setBasicCfg();
    runSequence(1'b0, 100, 0, -1, -1);

    $display("[TB] ack held low on second address");
    runSequence(1'b0, 100, 0, 1, -1);

    $display("[TB] stall after two transfers");
    runSequence(1'b0, 100, 0, -1, 2);

    $display("[TB] abort during work");
    ack = 1'b1;
    startRun();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ack = 1'b0;
    checkOutput("abortRdy", 32'(rdy), 0);
    checkOutput("abortBusy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("abortDone", 32'(done), 0);
      @(negedge clk);
    end
    runSequence(1'b0, 100, 0, -1, -1);

    $display("[TB] degenerate sizes");
    sz = '{0, 1, 0, 1};
    st = '{7, 9, 3, 5};
    bs = 'h2A5;
    runSequence(1'b0, 100, 0, -1, -1);

    $display("[TB] 4-bit address wrap");
    sz = '{4, 1, 1, 1};
    st = '{1, 0, 0, 0};
    bs = 'hE;
    runSequence(1'b1, 100, 0, -1, -1);

    $display("[TB] reset mid-run");
    setBasicCfg();
    ack = 1'b1;
    startRun();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstRdy", 32'(rdy), 0);
    checkOutput("midRstAddr", 32'(addr), 0);
    checkOutput("midRstIdx", idx, 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    checkOutput("midRstDone", 32'(done), 0);
    rst = 1'b0;
    ack = 1'b0;
    @(negedge clk);
    checkOutput("postRstDone", 32'(done), 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 4; k++) begin
        sz[k] = (k == 0) ? $urandom_range(0, 5) : $urandom_range(0, 3);
        st[k] = $urandom_range(0, 255);
      end
      bs = $urandom_range(0, 1023);
      runSequence(r >= 7, 70, 10, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
